// File: rtl/m_mem_pkg.sv
// Shared definitions for the CPU memory read controller and the address
// decoder it uses.
//
// Contents:
//   region_e   - memory region selected by an address (instr ROM, MMR, stack)
//   INSTR_END  - last address that belongs to the instruction ROM
//   MMR_END    - last address that belongs to the memory-mapped registers
//   state_e    - read controller FSM states
package m_mem_pkg;

  typedef enum logic [1:0] {
    REG_INSTR = 2'd0,
    REG_MMR   = 2'd1,
    REG_STACK = 2'd2
  } region_e;

  // Inclusive upper bounds; the stack region runs from MMR_END+1 to 0xFFF.
  localparam logic [11:0] INSTR_END = 12'h400;
  localparam logic [11:0] MMR_END   = 12'h44B;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/m_region_decode.sv
// Combinational address-to-region decoder. It is shared between the read and
// write sides of the CPU memory port, so every 12-bit address maps to exactly
// one region.
//
// Ports:
//   addr   in  12  byte/word address from the CPU
//   region out  2  REG_INSTR, REG_MMR or REG_STACK (never 3)
module m_region_decode
  import m_mem_pkg::*;
(
  input  logic [11:0] addr,
  output region_e     region
);

  // The regions are contiguous and ordered, so two compares are enough.
  always_comb begin
    region = REG_STACK;
    if (addr <= INSTR_END) begin
      region = REG_INSTR;
    end else if (addr <= MMR_END) begin
      region = REG_MMR;
    end
  end

endmodule

// File: rtl/m_mem_read_ctrl.sv
// CPU load controller. Accepts one read request at a time, decodes the
// address into instruction ROM, MMR or stack RAM, pulses that region's read
// strobe for one cycle, waits out the region's fixed read latency, captures
// the returned word and holds it for the CPU under a valid/ready handshake.
//
// Parameters:
//   DATA_W     data word width
//   INSTR_LAT  strobe-to-data latency of the instruction ROM (0..7)
//   MMR_LAT    strobe-to-data latency of the MMR block (0..7, 0 = same cycle)
//   STACK_LAT  strobe-to-data latency of the stack RAM (0..7)
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   rd_req, rd_addr   CPU read request and address (sampled on accept)
//   rd_ready          high only while idle; accept = rd_req && rd_ready
//   rd_valid, rd_data registered response word and its valid flag
//   rsp_ready         CPU takes the response when rd_valid && rsp_ready
//   sel, mem_addr     latched region and address towards the memories
//   instr_re, mmr_re, stack_re          one-cycle read strobes
//   instr_rdata, mmr_rdata, stack_rdata region read data
module m_mem_read_ctrl
  import m_mem_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int INSTR_LAT = 1,
  parameter int MMR_LAT   = 0,
  parameter int STACK_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [11:0]       rd_addr,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rsp_ready,
  output logic [1:0]        sel,
  output logic [11:0]       mem_addr,
  output logic              instr_re,
  output logic              mmr_re,
  output logic              stack_re,
  input  logic [DATA_W-1:0] instr_rdata,
  input  logic [DATA_W-1:0] mmr_rdata,
  input  logic [DATA_W-1:0] stack_rdata
);

  localparam logic [2:0] INSTR_LAT_C = 3'(INSTR_LAT);
  localparam logic [2:0] MMR_LAT_C   = 3'(MMR_LAT);
  localparam logic [2:0] STACK_LAT_C = 3'(STACK_LAT);

  state_e            state;
  state_e            state_next;
  logic [2:0]        cnt;
  region_e           dec_region;
  logic [2:0]        sel_lat;
  logic [DATA_W-1:0] sel_rdata;
  logic              capture;

  m_region_decode u_decode (
    .addr   (rd_addr),
    .region (dec_region)
  );

  // Latency and read data of the latched region. Code 3 never gets latched,
  // so it simply falls in with the stack.
  always_comb begin
    sel_lat   = STACK_LAT_C;
    sel_rdata = stack_rdata;
    case (region_e'(sel))
      REG_INSTR: begin
        sel_lat   = INSTR_LAT_C;
        sel_rdata = instr_rdata;
      end
      REG_MMR: begin
        sel_lat   = MMR_LAT_C;
        sel_rdata = mmr_rdata;
      end
      default: begin
        sel_lat   = STACK_LAT_C;
        sel_rdata = stack_rdata;
      end
    endcase
  end

  // A zero-latency region returns its data in the strobe cycle itself;
  // otherwise the data is taken when the countdown reaches 1.
  assign capture = ((state == ISSUE) && (sel_lat == 3'd0)) ||
                   ((state == WAIT) && (cnt == 3'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    rd_ready   = 1'b0;
    instr_re   = 1'b0;
    mmr_re     = 1'b0;
    stack_re   = 1'b0;
    case (state)
      IDLE: begin
        rd_ready = 1'b1;
        if (rd_req) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        instr_re   = (sel == REG_INSTR);
        mmr_re     = (sel == REG_MMR);
        stack_re   = (sel == REG_STACK);
        state_next = (sel_lat == 3'd0) ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt == 3'd1) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, latency countdown and response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 3'd0;
      sel      <= 2'd0;
      mem_addr <= 12'd0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_req) begin
            mem_addr <= rd_addr;
            sel      <= dec_region;
          end
        end
        ISSUE: begin
          cnt <= sel_lat;
        end
        WAIT: begin
          if (cnt != 3'd1) begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rd_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
      if (capture) begin
        rd_data  <= sel_rdata;
        rd_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_m_mem_read_ctrl.sv
// Self-checking bench for m_mem_read_ctrl. Two instances share clock, reset,
// address, rsp_ready and rdata: one with default latencies, one with
// INSTR_LAT=0 / STACK_LAT=7. Each has its own request line and its own
// transaction-level reference model.
module tb_m_mem_read_ctrl;

  localparam int LI_A = 1, LM_A = 0, LS_A = 2;
  localparam int LI_B = 0, LM_B = 0, LS_B = 7;

  typedef struct {
    bit          busy;
    bit          valid;
    int          t_acc;
    logic [1:0]  region;
    logic [11:0] addr;
    logic [15:0] data;
  } model_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [11:0] rd_addr = '0;
  logic        rsp_ready = 1'b0;
  logic [15:0] instr_rdata = '0, mmr_rdata = '0, stack_rdata = '0;

  logic        rdy_a, vld_a, ire_a, mre_a, sre_a;
  logic [15:0] dat_a;
  logic [1:0]  sel_a;
  logic [11:0] adr_a;
  logic        rdy_b, vld_b, ire_b, mre_b, sre_b;
  logic [15:0] dat_b;
  logic [1:0]  sel_b;
  logic [11:0] adr_b;

  int     tests = 0;
  int     fails = 0;
  int     cyc = 0;
  bit     run_cmp = 1'b0;
  bit     rand_rdata = 1'b0;
  model_t ma, mb;

  always #5 clk = ~clk;

  m_mem_read_ctrl #(.DATA_W(16), .INSTR_LAT(LI_A), .MMR_LAT(LM_A), .STACK_LAT(LS_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_req(req_a), .rd_addr(rd_addr), .rd_ready(rdy_a),
    .rd_valid(vld_a), .rd_data(dat_a), .rsp_ready(rsp_ready), .sel(sel_a), .mem_addr(adr_a),
    .instr_re(ire_a), .mmr_re(mre_a), .stack_re(sre_a), .instr_rdata(instr_rdata),
    .mmr_rdata(mmr_rdata), .stack_rdata(stack_rdata)
  );

  m_mem_read_ctrl #(.DATA_W(16), .INSTR_LAT(LI_B), .MMR_LAT(LM_B), .STACK_LAT(LS_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_req(req_b), .rd_addr(rd_addr), .rd_ready(rdy_b),
    .rd_valid(vld_b), .rd_data(dat_b), .rsp_ready(rsp_ready), .sel(sel_b), .mem_addr(adr_b),
    .instr_re(ire_b), .mmr_re(mre_b), .stack_re(sre_b), .instr_rdata(instr_rdata),
    .mmr_rdata(mmr_rdata), .stack_rdata(stack_rdata)
  );

  function automatic logic [1:0] region_of(logic [11:0] a);
    if (a <= 12'h400) return 2'd0;
    if (a <= 12'h44B) return 2'd1;
    return 2'd2;
  endfunction

  // One clock edge of a read transaction: accept when idle, capture the
  // selected region's data LAT cycles after the strobe cycle, and retire on
  // the handshake.
  function automatic model_t step(model_t m, int c, bit req, logic [11:0] a, bit rr,
                                  logic [15:0] di, logic [15:0] dm, logic [15:0] ds,
                                  int li, int lm, int ls);
    model_t n = m;
    int lat;
    if (!m.busy) begin
      if (req) begin
        n.busy   = 1'b1;
        n.t_acc  = c;
        n.addr   = a;
        n.region = region_of(a);
      end
    end else if (m.valid) begin
      if (rr) begin
        n.busy  = 1'b0;
        n.valid = 1'b0;
      end
    end else begin
      lat = (m.region == 2'd0) ? li : (m.region == 2'd1) ? lm : ls;
      if (c == m.t_acc + 1 + lat) begin
        n.valid = 1'b1;
        n.data  = (m.region == 2'd0) ? di : (m.region == 2'd1) ? dm : ds;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '{busy: 1'b0, valid: 1'b0, t_acc: 0, region: 2'd0, addr: 12'd0, data: 16'd0};
      mb <= '{busy: 1'b0, valid: 1'b0, t_acc: 0, region: 2'd0, addr: 12'd0, data: 16'd0};
    end else begin
      ma  <= step(ma, cyc, req_a, rd_addr, rsp_ready, instr_rdata, mmr_rdata, stack_rdata, LI_A, LM_A, LS_A);
      mb  <= step(mb, cyc, req_b, rd_addr, rsp_ready, instr_rdata, mmr_rdata, stack_rdata, LI_B, LM_B, LS_B);
      cyc <= cyc + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic compareInst(input string tag, input model_t m, input logic rdy, input logic vld,
                             input logic [15:0] dat, input logic [1:0] s, input logic [11:0] ad,
                             input logic ire, input logic mre, input logic sre);
    bit stb;
    stb = m.busy && !m.valid && (cyc == m.t_acc + 1);
    checkOutput({tag, ".rd_ready"}, 32'(rdy), 32'(!m.busy));
    checkOutput({tag, ".rd_valid"}, 32'(vld), 32'(m.valid));
    checkOutput({tag, ".rd_data"},  32'(dat), 32'(m.data));
    checkOutput({tag, ".sel"},      32'(s),   32'(m.region));
    checkOutput({tag, ".mem_addr"}, 32'(ad),  32'(m.addr));
    checkOutput({tag, ".instr_re"}, 32'(ire), 32'(stb && m.region == 2'd0));
    checkOutput({tag, ".mmr_re"},   32'(mre), 32'(stb && m.region == 2'd1));
    checkOutput({tag, ".stack_re"}, 32'(sre), 32'(stb && m.region == 2'd2));
  endtask

  always @(negedge clk) begin
    if (rst_n && run_cmp) begin
      compareInst("a", ma, rdy_a, vld_a, dat_a, sel_a, adr_a, ire_a, mre_a, sre_a);
      compareInst("b", mb, rdy_b, vld_b, dat_b, sel_b, adr_b, ire_b, mre_b, sre_b);
    end
  end

  task automatic tickDrive();
    @(negedge clk);
    if (rand_rdata) begin
      instr_rdata = 16'($urandom);
      mmr_rdata   = 16'($urandom);
      stack_rdata = 16'($urandom);
    end
  endtask

  // One complete read on instance a (inst=0) or b (inst=1). Negative
  // exp_delay / exp_sel skip the literal checks.
  task automatic applyStimulus(input bit inst, input logic [11:0] addr, input int hold,
                               input bit early_rsp, input bit noise, input int exp_delay,
                               input int exp_sel, input bit chk_data, input logic [15:0] exp_data);
    int t;
    bit got;
    tickDrive();
    rd_addr   = addr;
    rsp_ready = early_rsp;
    if (inst) req_b = 1'b1; else req_a = 1'b1;
    t   = cyc;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tickDrive();
      req_a = 1'b0;
      req_b = 1'b0;
      if ((inst ? vld_b : vld_a) === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (noise) begin
        rd_addr = 12'($urandom);
        if ($urandom_range(1) == 1) begin
          if (inst) req_b = 1'b1; else req_a = 1'b1;
        end
      end
    end
    if (!got) begin
      checkOutput("valid_timeout", 32'd0, 32'd1);
      rsp_ready = 1'b1;
      repeat (3) tickDrive();
      rsp_ready = 1'b0;
      return;
    end
    if (exp_delay >= 0) checkOutput("accept_to_valid", 32'(cyc - t), 32'(exp_delay));
    if (exp_sel >= 0)   checkOutput("sel_literal", 32'(inst ? sel_b : sel_a), 32'(exp_sel));
    if (chk_data)       checkOutput("data_literal", 32'(inst ? dat_b : dat_a), 32'(exp_data));
    if (!early_rsp) begin
      for (int k = 0; k < hold; k++) begin
        tickDrive();
        if (noise) begin
          rd_addr = 12'($urandom);
          if (inst) req_b = 1'b1; else req_a = 1'b1;
        end
        checkOutput("ready_low_in_hold", 32'(inst ? rdy_b : rdy_a), 32'd0);
      end
      req_a     = 1'b0;
      req_b     = 1'b0;
      rsp_ready = 1'b1;
    end
    tickDrive();
    rsp_ready = 1'b0;
    checkOutput("ready_after_handshake", 32'(inst ? rdy_b : rdy_a), 32'd1);
    checkOutput("valid_after_handshake", 32'(inst ? vld_b : vld_a), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [11:0] bounds [5];
    int          bsel   [5];
    bounds = '{12'h400, 12'h401, 12'h44B, 12'h44C, 12'hFFF};
    bsel   = '{0, 1, 1, 2, 2};

    #3;
    checkOutput("reset.rd_ready", 32'(rdy_a), 32'd1);
    checkOutput("reset.rd_valid", 32'(vld_a), 32'd0);
    checkOutput("reset.sel", 32'(sel_a), 32'd0);
    repeat (3) @(negedge clk);
    rst_n   = 1'b1;
    run_cmp = 1'b1;

    // Region boundaries on both sides of each limit.
    foreach (bounds[i]) applyStimulus(1'b0, bounds[i], 1, 1'b0, 1'b0, -1, bsel[i], 1'b0, 16'h0);

    // Default latencies with fixed read data.
    mmr_rdata = 16'h1234; instr_rdata = 16'hBEEF; stack_rdata = 16'h00A5;
    applyStimulus(1'b0, 12'h401, 0, 1'b0, 1'b0, 2, 1, 1'b1, 16'h1234);
    applyStimulus(1'b0, 12'h000, 0, 1'b0, 1'b0, 3, 0, 1'b1, 16'hBEEF);
    applyStimulus(1'b0, 12'h800, 0, 1'b0, 1'b0, 4, 2, 1'b1, 16'h00A5);

    // Backpressure with ignored requests and address churn.
    stack_rdata = 16'h5A3C;
    applyStimulus(1'b0, 12'h900, 5, 1'b0, 1'b1, 4, 2, 1'b1, 16'h5A3C);

    // Other regions' data must not leak into an MMR read.
    instr_rdata = 16'hFFFF; stack_rdata = 16'hFFFF; mmr_rdata = 16'h0F0F;
    applyStimulus(1'b0, 12'h420, 1, 1'b0, 1'b0, 2, 1, 1'b1, 16'h0F0F);

    // Reset in the middle of a stack read.
    stack_rdata = 16'h7777;
    tickDrive();
    rd_addr = 12'h800;
    req_a   = 1'b1;
    tickDrive();
    req_a = 1'b0;
    tickDrive();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset.rd_ready", 32'(rdy_a), 32'd1);
    checkOutput("midreset.rd_valid", 32'(vld_a), 32'd0);
    checkOutput("midreset.rd_data", 32'(dat_a), 32'd0);
    checkOutput("midreset.sel", 32'(sel_a), 32'd0);
    checkOutput("midreset.mem_addr", 32'(adr_a), 32'd0);
    checkOutput("midreset.stack_re", 32'(sre_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    instr_rdata = 16'h0C0D;
    applyStimulus(1'b0, 12'h044, 0, 1'b0, 1'b0, 3, 0, 1'b1, 16'h0C0D);

    // Long stack and zero-latency instruction on the second instance.
    stack_rdata = 16'hCAFE; instr_rdata = 16'h1357;
    applyStimulus(1'b1, 12'hABC, 0, 1'b0, 1'b0, 9, 2, 1'b1, 16'hCAFE);
    applyStimulus(1'b1, 12'h123, 0, 1'b0, 1'b0, 2, 0, 1'b1, 16'h1357);

    // Randomized reads; rdata changes every cycle so capture timing matters.
    rand_rdata = 1'b1;
    for (int n = 0; n < 60; n++) begin
      logic [11:0] a;
      a = ($urandom_range(1) == 1) ? bounds[$urandom_range(4)] : 12'($urandom);
      applyStimulus(bit'(n % 2), a, $urandom_range(3), bit'($urandom_range(1)),
                    bit'($urandom_range(1)), -1, int'(region_of(a)), 1'b0, 16'h0);
    end
    rand_rdata = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/m_mem_read_ctrl.md
# m_mem_read_ctrl

Read-side companion to the CPU's memory-write address decoding. Accepts one CPU load request at a time, decodes the 12-bit address into instruction ROM, memory-mapped registers (MMR) or stack RAM, and issues a one-cycle read strobe to that region. It then waits out the region's fixed read latency, captures the returned word and presents it to the CPU with a valid/ready handshake. The block sits between the CPU datapath's memory-read port and the three memory regions.

## Interface
- DATA_W, 16: data word width.
- INSTR_LAT, 1: cycles from the instruction strobe to valid instr_rdata (0..7).
- MMR_LAT, 0: cycles from the MMR strobe to valid mmr_rdata (0..7; 0 means same cycle).
- STACK_LAT, 2: cycles from the stack strobe to valid stack_rdata (0..7).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_req  in  1  CPU read request.
- rd_addr  in  12  read address, sampled on accept.
- rd_ready  out  1  high only in IDLE; a request is accepted when rd_req && rd_ready.
- rd_valid  out  1  read data valid.
- rd_data  out  DATA_W  captured read word.
- rsp_ready  in  1  CPU consumes the response when rd_valid && rsp_ready.
- sel  out  2  latched region: 0 instr, 1 MMR, 2 stack. 3 is never driven.
- mem_addr  out  12  latched address to the regions.
- instr_re, mmr_re, stack_re  out  1 each  one-cycle read strobes; at most one is high in any cycle.
- instr_rdata, mmr_rdata, stack_rdata  in  DATA_W each  region read data.

## Operation
- Address map (inclusive): instr 0x000–0x400, MMR 0x401–0x44B, stack 0x44C–0xFFF. Every address decodes to exactly one region.
- FSM states:
  - IDLE: on accept, latch rd_addr into mem_addr and the decoded region into sel, then go to ISSUE.
  - ISSUE: assert the strobe for sel and load cnt with that region's LAT value. If LAT == 0, capture the region's rdata and go to RESP; otherwise go to WAIT.
  - WAIT: each cycle, if cnt == 1 capture rdata and go to RESP; otherwise decrement cnt.
  - RESP: hold rd_valid and rd_data; on rsp_ready go to IDLE.
- cnt is 3 bits.
- The captured word comes from the rdata input selected by sel. The other rdata inputs are ignored.
- No back-to-back requests: the next request can be accepted no earlier than the cycle after the RESP handshake.
- rd_req is ignored outside IDLE.
- rd_addr changes after accept have no effect.

## Timing
- Reset (asynchronous, any state, including mid-WAIT): state IDLE, rd_ready=1, rd_valid=0, rd_data=0, sel=0, mem_addr=0, all strobes 0, cnt=0. Any in-flight read is discarded.
- Accept at cycle T:
  - strobe at T+1;
  - capture at the edge ending cycle T+1+LAT;
  - rd_valid from T+2+LAT.
- Default latencies: MMR rd_valid at T+2, instr at T+3, stack at T+4.
- rd_valid stays high and rd_data stays stable until the rsp_ready handshake. rd_valid drops in the following cycle, and rd_ready rises in that same cycle.
- rsp_ready may be high before rd_valid; the handshake completes in the first RESP cycle.
- All outputs are registered except rd_ready and the strobes, which are decoded from the state.

## Structure
- Package m_mem_pkg holds:
  - region enum (REG_INSTR=0, REG_MMR=1, REG_STACK=2);
  - INSTR_END=12'h400 and MMR_END=12'h44B;
  - FSM state enum (IDLE, ISSUE, WAIT, RESP).
- Sub-module m_region_decode: combinational, 12-bit address in, 2-bit region out, using the package constants. The write-side decoder can reuse it.
- The top level contains the FSM, latency counter, capture register and rdata mux.

## Test plan
- Boundary decode: read 0x400, then 0x401, 0x44B, 0x44C, 0xFFF -> sel = 0, 1, 1, 2, 2, and only the matching strobe pulses for one cycle.
- Latency: accept at T for 0x401 (mmr_rdata=0x1234), 0x000 (instr_rdata=0xBEEF) and 0x800 (stack_rdata=0x00A5) -> rd_valid at T+2, T+3 and T+4 respectively, with the correct rd_data.
- Backpressure: hold rsp_ready=0 for 5 cycles on a stack read -> rd_valid and rd_data stay stable, rd_ready stays 0, and a rd_req during that window is not accepted.
- Isolation: drive a wrong-region rdata to 0xFFFF during an MMR read -> rd_data equals mmr_rdata only.
- Reset mid-read: assert rst_n=0 during WAIT of a stack read -> all outputs immediately take their reset values; after release, a new read of 0x044 completes normally.
- Parameter sweep: STACK_LAT=7 and INSTR_LAT=0 -> rd_valid at T+9 and T+2 respectively.
